// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S-family transmitter.
//   fmt_e       : wire format encodings (I2S, left-justified, right-justified)
//   calc_inc    : fractional clock-enable accumulator increment
//   msb_index   : slot bit index that carries the sample MSB for a format
package i2s_pkg;

  typedef enum logic [1:0] {
    FMT_I2S = 2'd0,
    FMT_LJ  = 2'd1,
    FMT_RJ  = 2'd2,
    FMT_RSV = 2'd3
  } fmt_e;

  // Two ce pulses per bit (one per sclk edge), two slots per frame.
  function automatic logic [31:0] calc_inc(input int unsigned freq, input int unsigned slot_dw);
    return 32'(freq * 2 * slot_dw * 2);
  endfunction

  function automatic int msb_index(input fmt_e f, input int slot_dw, input int audio_dw);
    case (f)
      FMT_LJ:  return 0;
      FMT_RJ:  return slot_dw - audio_dw;
      default: return 1;
    endcase
  endfunction

endpackage

// File: rtl/i2s_tx_fmt_mavg.sv
// Single-channel moving average over the last 2**FILT_LOG2 loaded samples,
// kept as a running sum so each load costs one add and one subtract.
//   clk, reset_n : system clock, asynchronous active-low reset
//   load         : enter din into the window (one strobe per frame)
//   din          : signed sample entering the window
//   dout         : registered average, updated on the clock after load
module i2s_mavg #(
  parameter int AUDIO_DW  = 16,
  parameter int FILT_LOG2 = 3
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       load,
  input  logic signed [AUDIO_DW-1:0] din,
  output logic signed [AUDIO_DW-1:0] dout
);

  localparam int DEPTH = 2 ** FILT_LOG2;
  localparam int SW    = AUDIO_DW + FILT_LOG2;

  logic signed [AUDIO_DW-1:0]  mem_q [DEPTH];
  logic signed [AUDIO_DW-1:0]  mem_d [DEPTH];
  logic        [FILT_LOG2-1:0] ptr_q, ptr_d;
  logic signed [SW-1:0]        sum_q, sum_d;
  logic signed [AUDIO_DW-1:0]  dout_q, dout_d;
  logic signed [SW-1:0]        din_x, old_x;

  always_comb begin
    mem_d  = mem_q;
    ptr_d  = ptr_q;
    sum_d  = sum_q;
    dout_d = dout_q;
    din_x  = {{FILT_LOG2{din[AUDIO_DW-1]}}, din};
    old_x  = {{FILT_LOG2{mem_q[ptr_q][AUDIO_DW-1]}}, mem_q[ptr_q]};
    if (load) begin
      sum_d        = sum_q + din_x - old_x;
      mem_d[ptr_q] = din;
      ptr_d        = ptr_q + FILT_LOG2'(1);
      // Dropping the low FILT_LOG2 bits of a signed sum is an arithmetic
      // right shift; the window can never exceed AUDIO_DW bits of average.
      dout_d       = sum_d[SW-1:FILT_LOG2];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      ptr_q  <= '0;
      sum_q  <= '0;
      dout_q <= '0;
    end else begin
      mem_q  <= mem_d;
      ptr_q  <= ptr_d;
      sum_q  <= sum_d;
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/i2s_tx_fmt.sv
// I2S / left-justified / right-justified audio serialiser with valid/ready
// sample intake, underrun reporting and an optional moving-average filter.
//   clk, reset_n            : system clock, asynchronous active-low reset
//   clk_rate                : clk frequency in Hz (static)
//   fmt, filter_en          : wire format and filter select, sampled per frame
//   left_chan, right_chan   : signed sample pair, offered with sample_valid
//   sample_ready            : holding register empty
//   sclk, lrclk, sdata      : DAC pins, data changes on sclk falling edge
//   underrun                : one-clk pulse when a frame starts with no new pair
module i2s_tx_fmt
  import i2s_pkg::*;
#(
  parameter int I2S_FREQ  = 48000,
  parameter int AUDIO_DW  = 16,
  parameter int SLOT_DW   = 32,
  parameter int FILT_LOG2 = 3
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [31:0]                clk_rate,
  input  logic [1:0]                 fmt,
  input  logic                       filter_en,
  input  logic signed [AUDIO_DW-1:0] left_chan,
  input  logic signed [AUDIO_DW-1:0] right_chan,
  input  logic                       sample_valid,
  output logic                       sample_ready,
  output logic                       sclk,
  output logic                       lrclk,
  output logic                       sdata,
  output logic                       underrun
);

  localparam logic [31:0] INC     = calc_inc(I2S_FREQ, SLOT_DW);
  localparam int          BW      = $clog2(2 * SLOT_DW);
  localparam logic [BW-1:0] BC_LAST = BW'(2 * SLOT_DW - 1);

  logic [31:0]                cnt_q, cnt_d;
  logic                       ce_q, ce_d;
  logic                       sclk_q, sclk_d;
  logic                       lrclk_q, lrclk_d;
  logic                       sdata_q, sdata_d;
  logic [BW-1:0]              bit_cnt_q, bit_cnt_d;
  fmt_e                       fmt_q, fmt_d;
  logic                       sample_ready_q, sample_ready_d;
  logic                       underrun_q, underrun_d;
  logic signed [AUDIO_DW-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic signed [AUDIO_DW-1:0] last_l_q, last_l_d, last_r_q, last_r_d;
  logic signed [AUDIO_DW-1:0] tx_l_q, tx_l_d, tx_r_q, tx_r_d;

  logic [32:0]                cnt_sum;
  logic                       fall, boundary, full, accept;
  logic signed [AUDIO_DW-1:0] in_l, in_r, filt_l, filt_r, samp;
  logic [AUDIO_DW-1:0]        sh;
  logic                       slot;
  int                         idx, pos;

  i2s_mavg #(.AUDIO_DW(AUDIO_DW), .FILT_LOG2(FILT_LOG2)) u_mavg_l (
    .clk(clk), .reset_n(reset_n), .load(boundary), .din(in_l), .dout(filt_l)
  );

  i2s_mavg #(.AUDIO_DW(AUDIO_DW), .FILT_LOG2(FILT_LOG2)) u_mavg_r (
    .clk(clk), .reset_n(reset_n), .load(boundary), .din(in_r), .dout(filt_r)
  );

  always_comb begin
    // Fractional clock enable; too-slow a system clock degenerates to ce every clk.
    cnt_sum = {1'b0, cnt_q} + {1'b0, INC};
    if ({1'b0, clk_rate} < {INC, 1'b0}) begin
      ce_d  = 1'b1;
      cnt_d = '0;
    end else if (cnt_sum >= {1'b0, clk_rate}) begin
      ce_d  = 1'b1;
      cnt_d = cnt_sum[31:0] - clk_rate;
    end else begin
      ce_d  = 1'b0;
      cnt_d = cnt_sum[31:0];
    end

    sclk_d    = ce_q ? ~sclk_q : sclk_q;
    fall      = ce_q & sclk_q;
    boundary  = fall && (bit_cnt_q == BC_LAST);
    bit_cnt_d = bit_cnt_q;
    if (fall) bit_cnt_d = boundary ? '0 : bit_cnt_q + BW'(1);

    fmt_d = fmt_q;
    if (boundary) fmt_d = (fmt == 2'd3) ? FMT_I2S : fmt_e'(fmt);

    // Intake: the holding register is full exactly when ready is low.
    full           = ~sample_ready_q;
    accept         = sample_valid & sample_ready_q;
    sample_ready_d = sample_ready_q;
    if (accept)                sample_ready_d = 1'b0;
    else if (boundary && full) sample_ready_d = 1'b1;
    hold_l_d   = accept ? left_chan  : hold_l_q;
    hold_r_d   = accept ? right_chan : hold_r_q;
    underrun_d = boundary & ~full;

    // On underrun the previous pair is re-entered so the filter keeps its cadence.
    in_l     = full ? hold_l_q : last_l_q;
    in_r     = full ? hold_r_q : last_r_q;
    last_l_d = boundary ? in_l : last_l_q;
    last_r_d = boundary ? in_r : last_r_q;

    // Transmit the result formed at the previous boundary: one frame of latency.
    tx_l_d = tx_l_q;
    tx_r_d = tx_r_q;
    if (boundary) begin
      tx_l_d = filter_en ? filt_l : last_l_q;
      tx_r_d = filter_en ? filt_r : last_r_q;
    end

    lrclk_d = lrclk_q;
    sdata_d = sdata_q;
    slot    = 1'b0;
    idx     = 0;
    pos     = 0;
    samp    = '0;
    sh      = '0;
    if (fall) begin
      slot    = (bit_cnt_d >= BW'(SLOT_DW));
      idx     = int'(bit_cnt_d) - (slot ? SLOT_DW : 0);
      pos     = idx - msb_index(fmt_d, SLOT_DW, AUDIO_DW);
      samp    = slot ? tx_r_d : tx_l_d;
      sh      = samp << pos;
      sdata_d = (pos >= 0 && pos < AUDIO_DW) ? sh[AUDIO_DW-1] : 1'b0;
      lrclk_d = (fmt_d == FMT_I2S) ? slot : ~slot;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q          <= '0;
      ce_q           <= 1'b0;
      sclk_q         <= 1'b1;
      lrclk_q        <= 1'b1;
      sdata_q        <= 1'b0;
      bit_cnt_q      <= BC_LAST;
      fmt_q          <= FMT_I2S;
      sample_ready_q <= 1'b1;
      underrun_q     <= 1'b0;
      hold_l_q       <= '0;
      hold_r_q       <= '0;
      last_l_q       <= '0;
      last_r_q       <= '0;
      tx_l_q         <= '0;
      tx_r_q         <= '0;
    end else begin
      cnt_q          <= cnt_d;
      ce_q           <= ce_d;
      sclk_q         <= sclk_d;
      lrclk_q        <= lrclk_d;
      sdata_q        <= sdata_d;
      bit_cnt_q      <= bit_cnt_d;
      fmt_q          <= fmt_d;
      sample_ready_q <= sample_ready_d;
      underrun_q     <= underrun_d;
      hold_l_q       <= hold_l_d;
      hold_r_q       <= hold_r_d;
      last_l_q       <= last_l_d;
      last_r_q       <= last_r_d;
      tx_l_q         <= tx_l_d;
      tx_r_q         <= tx_r_d;
    end
  end

  assign sample_ready = sample_ready_q;
  assign sclk         = sclk_q;
  assign lrclk        = lrclk_q;
  assign sdata        = sdata_q;
  assign underrun     = underrun_q;

endmodule
